// File: rtl/mem_stage_pkg.sv
// Shared types and decode helpers for the MINA MEM stage.
// Covers the memory op encoding, the EX/MEM and MEM/WB payloads, and the FSM state type.
package mem_stage_pkg;

    localparam int unsigned REG_ADDR_W = 4;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic {
        StIdle,
        StBusy
    } mem_state_t;

    // rd_data carries the ALU result, or the effective address for memory ops.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [31:0]           rd_data;
        mem_op_t               mem_op;
        logic [31:0]           mem_data;
    } mem_params_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [31:0]           rd_data;
        logic                  rd_we;
    } wb_params_t;

    function automatic logic is_mem_op(mem_op_t op);
        return op != MEM_OP_NONE;
    endfunction

    function automatic logic is_store(mem_op_t op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(mem_op_t op, logic [1:0] lane);
        logic w_mis;
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: w_mis = lane[0];
            MEM_OP_LW, MEM_OP_SW:             w_mis = (lane != 2'b00);
            default:                          w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-master data bus with req/ack handshake between the MEM stage and memory.
// For loads, dbus_rdata is valid in the same cycle as dbus_ack.
interface mem_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              dbus_req;
    logic              dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [3:0]        dbus_be;
    logic [DATA_W-1:0] dbus_wdata;
    logic              dbus_ack;
    logic [DATA_W-1:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_be,
        output dbus_wdata,
        input  dbus_ack,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_be,
        input  dbus_wdata,
        output dbus_ack,
        output dbus_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: byte enables and replicated store data for a request,
// and lane extraction with sign/zero extension for a load response.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_data[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_data;
        o_load  = 32'h0;
        case (i_op)
            MEM_OP_LB: begin
                o_be   = 4'b0001 << i_lane;
                o_load = {{24{w_byte[7]}}, w_byte};
            end
            MEM_OP_LBU: begin
                o_be   = 4'b0001 << i_lane;
                o_load = {24'h0, w_byte};
            end
            MEM_OP_LH: begin
                o_be   = i_lane[1] ? 4'b1100 : 4'b0011;
                o_load = {{16{w_half[15]}}, w_half};
            end
            MEM_OP_LHU: begin
                o_be   = i_lane[1] ? 4'b1100 : 4'b0011;
                o_load = {16'h0, w_half};
            end
            MEM_OP_LW: begin
                o_be   = 4'b1111;
                o_load = i_data;
            end
            MEM_OP_SB: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_data[7:0]}};
            end
            MEM_OP_SH: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_data[15:0]}};
            end
            MEM_OP_SW: begin
                o_be = 4'b1111;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the MINA pipeline: issues loads/stores on the data bus, stalls upstream while
// a transaction is outstanding, and produces registered MEM/WB writeback parameters.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_params_t mem_params_in,
    output logic        stall_o,
    mem_stage_if.master dbus,
    output wb_params_t  wb_params_out,
    output logic        misalign_o
);

    mem_state_t              r_state, w_state_next;
    mem_op_t                 r_op, w_op_next;
    logic [REG_ADDR_W-1:0]   r_rd_addr, w_rd_addr_next;
    logic [1:0]              r_lane, w_lane_next;
    logic                    r_req, w_req_next;
    logic                    r_we, w_we_next;
    logic [ADDR_W-1:0]       r_addr, w_addr_next;
    logic [3:0]              r_be, w_be_next;
    logic [DATA_W-1:0]       r_wdata, w_wdata_next;
    wb_params_t              r_wb, w_wb_next;
    logic                    r_misalign, w_misalign_next;

    mem_op_t                 w_al_op;
    logic [1:0]              w_al_lane;
    logic [DATA_W-1:0]       w_al_data;
    logic [3:0]              w_be;
    logic [DATA_W-1:0]       w_wdata;
    logic [DATA_W-1:0]       w_load;
    logic [1:0]              w_in_lane;

    assign w_in_lane = mem_params_in.rd_data[1:0];

    // One aligner serves both directions: request steering in IDLE, load extraction in BUSY.
    assign w_al_op   = (r_state == StBusy) ? r_op : mem_params_in.mem_op;
    assign w_al_lane = (r_state == StBusy) ? r_lane : w_in_lane;
    assign w_al_data = (r_state == StBusy) ? dbus.dbus_rdata : mem_params_in.mem_data;

    mem_lane_align u_lane_align (
        .i_op    (w_al_op),
        .i_lane  (w_al_lane),
        .i_data  (w_al_data),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_load  (w_load)
    );

    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_rd_addr_next  = r_rd_addr;
        w_lane_next     = r_lane;
        w_req_next      = r_req;
        w_we_next       = r_we;
        w_addr_next     = r_addr;
        w_be_next       = r_be;
        w_wdata_next    = r_wdata;
        w_wb_next       = '0;
        w_misalign_next = 1'b0;
        stall_o         = 1'b0;

        case (r_state)
            StIdle: begin
                if (!is_mem_op(mem_params_in.mem_op)) begin
                    w_wb_next.rd_addr = mem_params_in.rd_addr;
                    w_wb_next.rd_data = mem_params_in.rd_data;
                    w_wb_next.rd_we   = (mem_params_in.rd_addr != '0);
                end else if (is_misaligned(mem_params_in.mem_op, w_in_lane)) begin
                    w_misalign_next = 1'b1;
                end else begin
                    stall_o        = 1'b1;
                    w_state_next   = StBusy;
                    w_op_next      = mem_params_in.mem_op;
                    w_rd_addr_next = mem_params_in.rd_addr;
                    w_lane_next    = w_in_lane;
                    w_req_next     = 1'b1;
                    w_we_next      = is_store(mem_params_in.mem_op);
                    w_addr_next    = {mem_params_in.rd_data[ADDR_W-1:2], 2'b00};
                    w_be_next      = w_be;
                    w_wdata_next   = w_wdata;
                end
            end
            StBusy: begin
                if (!dbus.dbus_ack) begin
                    stall_o = 1'b1;
                end else begin
                    w_state_next = StIdle;
                    w_req_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_be_next    = 4'b0000;
                    if (!is_store(r_op)) begin
                        w_wb_next.rd_addr = r_rd_addr;
                        w_wb_next.rd_data = w_load;
                        w_wb_next.rd_we   = (r_rd_addr != '0);
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_op       <= MEM_OP_NONE;
            r_rd_addr  <= '0;
            r_lane     <= 2'b00;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= '0;
            r_wb       <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_rd_addr  <= w_rd_addr_next;
            r_lane     <= w_lane_next;
            r_req      <= w_req_next;
            r_we       <= w_we_next;
            r_addr     <= w_addr_next;
            r_be       <= w_be_next;
            r_wdata    <= w_wdata_next;
            r_wb       <= w_wb_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign dbus.dbus_req   = r_req;
    assign dbus.dbus_we    = r_we;
    assign dbus.dbus_addr  = r_addr;
    assign dbus.dbus_be    = r_be;
    assign dbus.dbus_wdata = r_wdata;
    assign wb_params_out   = r_wb;
    assign misalign_o      = r_misalign;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the MINA CPU pipeline. Consumes mem_params_t from the EX/MEM register and performs loads/stores over a single-master data bus with req/ack handshake.
- Produces registered writeback parameters for the MEM/WB path.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, register/bus data width; must be 32 (4 byte lanes).

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- mem_params_in  input  mem_params_t  from EX/MEM: rd_addr[3:0], rd_data[31:0] (ALU result, or effective address for memory ops), mem_op, mem_data[31:0] (store data)
- stall_o  output  1  combinational; holds EX/MEM and earlier stages
- dbus_req  output  1  registered bus request
- dbus_we  output  1  1 = store
- dbus_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0)
- dbus_be  output  4  byte enables
- dbus_wdata  output  32  lane-replicated store data
- dbus_ack  input  1  transaction complete; for loads, dbus_rdata is valid in the same cycle
- dbus_rdata  input  32  load data
- wb_params_out  output  wb_params_t  registered: rd_addr, rd_data, rd_we
- misalign_o  output  1  registered one-cycle pulse on a misaligned access

Behaviour:
- Reset (at the rst edge): state = IDLE; dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata = 0; wb_params_out = {0, 0, 0}; misalign_o = 0.
  - Reset mid-transaction abandons it; the bus must tolerate req dropping before ack.
- mem_op encodings: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW. A memory op is any op except NONE.
- Misaligned access: H ops with addr[0] != 0; W ops with addr[1:0] != 0.
- Lane mapping is little-endian. lane = addr[1:0].
  - SB: be = 1 << lane; wdata = {4{mem_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{mem_data[15:0]}}.
  - SW: be = 4'b1111.
  - Loads use the same be pattern with dbus_we = 0.
- Load data is extracted from the selected lane of dbus_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- State machine:
  - IDLE, op = NONE: next wb = {rd_addr, rd_data, rd_we = (rd_addr != 0)}; stall_o = 0; latency 1 cycle.
  - IDLE, misaligned op: no bus access; wb bubble {0, 0, 0}; misalign_o = 1 next cycle; stall_o = 0.
  - IDLE, aligned memory op: stall_o = 1; latch the op, rd_addr and lane; drive dbus_* registered; next state BUSY; wb bubble.
  - BUSY, dbus_ack = 0: dbus_req and all dbus_* held stable; stall_o = 1; wb bubble.
  - BUSY, dbus_ack = 1: stall_o = 0; dbus_req = 0 next cycle; next state IDLE.
    - Load: wb = {rd_addr, extended data, rd_addr != 0}.
    - Store: wb bubble.
- Minimum load latency: op presented at cycle 0, req in cycle 1, ack in cycle 1, wb valid at cycle 2.
- The EX/MEM input is held stable while stall_o = 1. While in BUSY, mem_params_in is ignored and the latched copy is used.
- Writes to r0 are never enabled (rd_we = 0).
- Back-to-back memory ops: after the ack cycle the state is IDLE, so the next op requests one cycle later. No request is issued in the ack cycle itself.

Decomposition:
- Package types holds:
  - mem_op_t enum with MEM_OP_NONE plus the ops above.
  - mem_params_t and wb_params_t structs.
  - Functions is_mem_op, is_store, is_misaligned.
- One sub-module, mem_lane_align (combinational): given op, addr[1:0] and data, returns be, replicated wdata, and the extended load result.

Test Plan:
- rst = 1 for 2 cycles mid-BUSY -> dbus_req = 0 and wb_params_out = 0 one cycle after the rst edge; state returns to IDLE.
- op = NONE, rd_addr = 5, rd_data = 0x1234 -> next cycle wb = {5, 0x1234, 1}; stall_o = 0 throughout; dbus_req never asserted.
- LB, addr = 0x1003, dbus_rdata = 0x80FFFFFF, ack after 3 wait cycles -> be = 4'b1000; wb.rd_data = 0xFFFFFF80; stall_o high for exactly 4 cycles; req stable throughout.
- LHU, addr = 0x2002, rdata = 0xBEEF0000, immediate ack -> be = 4'b1100; wb = 0x0000BEEF at cycle 2.
- SH, addr = 0x10, mem_data = 0xAAAA5555 -> dbus_we = 1, be = 4'b0011, wdata = 0x55555555; wb bubble.
- LW, addr = 0x6 -> misalign_o pulses one cycle; no dbus_req; stall_o = 0; wb bubble. Then LW, addr = 0x8, rd_addr = 0 -> transaction completes with rd_we = 0.
